// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
// The master modport is the fetch stage; the slave modport is memory/decode.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [15:0]       imem_rdata;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [15:0]       if_pc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch stage: owns the PC, fetches one 16-bit instruction at a
// time over req/gnt + rvalid, and holds it for decode until consumed or flushed.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_pc_next,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_pc_out,
  instr_fetch_unit_if.master io_fetch
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_VALID
  } state_t;

  state_t      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [15:0] r_addr, w_addr_d;
  logic        r_discard, w_discard_d;
  logic        r_pend, w_pend_d;
  logic [15:0] r_instr;
  logic [15:0] r_if_pc;
  logic        w_latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_discard <= 1'b0;
      r_pend    <= 1'b0;
      r_instr   <= 16'h0000;
      r_if_pc   <= 16'h0000;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_addr    <= w_addr_d;
      r_discard <= w_discard_d;
      r_pend    <= w_pend_d;
      if (w_latch) begin
        r_instr <= io_fetch.imem_rdata;
        r_if_pc <= r_pc;
      end
    end
  end

  // r_addr only changes on entry to FETCH, so a redirect that arrives before
  // the grant moves the PC without disturbing the outstanding request address.
  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_addr_d    = r_addr;
    w_discard_d = r_discard;
    w_pend_d    = r_pend;
    w_latch     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (i_redirect) w_pc_d = i_redirect_pc;
        if (io_fetch.imem_gnt) begin
          w_state_d   = S_WAIT;
          w_discard_d = r_pend | i_redirect;
          w_pend_d    = 1'b0;
        end else if (i_redirect) begin
          w_pend_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_redirect) begin
          w_pc_d = i_redirect_pc;
          if (io_fetch.imem_rvalid) begin
            w_state_d   = S_FETCH;
            w_addr_d    = i_redirect_pc;
            w_discard_d = 1'b0;
          end else begin
            w_discard_d = 1'b1;
          end
        end else if (io_fetch.imem_rvalid) begin
          if (r_discard) begin
            w_discard_d = 1'b0;
            w_state_d   = S_FETCH;
            w_addr_d    = r_pc;
          end else begin
            w_latch   = 1'b1;
            w_state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (i_redirect) begin
          w_pc_d    = i_redirect_pc;
          w_addr_d  = i_redirect_pc;
          w_state_d = S_FETCH;
        end else if (io_fetch.id_ready) begin
          w_pc_d    = i_pc_next;
          w_addr_d  = i_pc_next;
          w_state_d = S_FETCH;
        end
      end
      default: w_state_d = S_FETCH;
    endcase
  end

  assign io_fetch.imem_req  = (r_state == S_FETCH) & rst_n;
  assign io_fetch.imem_addr = ADDR_W'({r_addr[15:1], 1'b0});
  assign io_fetch.if_valid  = (r_state == S_VALID);
  assign io_fetch.if_instr  = r_instr;
  assign io_fetch.if_pc     = r_if_pc;
  assign o_pc_out           = r_pc;

endmodule
